// File: rtl/muldiv_sched_if.sv
// EX-stage <-> multiply/divide sequencer handshake and result bus.
interface muldiv_sched_if;
   logic        flush;
   logic        ex_stall;
   logic        op_valid;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic        res_valid;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output flush, ex_stall, op_valid, op, src_a, src_b,
      input  busy, res_valid, hi, lo
   );

   modport slave (
      input  flush, ex_stall, op_valid, op, src_a, src_b,
      output busy, res_valid, hi, lo
   );
endinterface

// File: rtl/muldiv_sched.sv
// EX-stage mul/div sequencer: pipelined multiplier, 32-step restoring divider,
// stall request until the {hi, lo} result is ready and consumed.
module muldiv_sched #(
   parameter int unsigned MUL_LAT = 2
) (
   input logic           clk,
   input logic           rst,
   muldiv_sched_if.slave bus
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

   state_e      state_q;
   logic [4:0]  cnt_q;
   logic [31:0] dvd_q;
   logic [31:0] dvs_q;
   logic [31:0] rem_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        sdiv_q;
   logic        sa_q;
   logic        sb_q;
   logic [63:0] pipe_q [MUL_LAT];

   logic        sdiv;
   logic [31:0] a_abs;
   logic [31:0] b_abs;
   logic [63:0] ma;
   logic [63:0] mb;
   logic [63:0] prod;
   logic [32:0] rem_sh;
   logic [32:0] diff;
   logic        ge;
   logic [31:0] rem_d;
   logic [31:0] quo_d;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   always_comb begin
      sdiv  = (bus.op == 2'b10);
      a_abs = (sdiv && bus.src_a[31]) ? -bus.src_a : bus.src_a;
      b_abs = (sdiv && bus.src_b[31]) ? -bus.src_b : bus.src_b;
      // Low 64 bits of a 64x64 product are sign-agnostic once operands are extended.
      ma    = bus.op[0] ? {32'b0, bus.src_a} : {{32{bus.src_a[31]}}, bus.src_a};
      mb    = bus.op[0] ? {32'b0, bus.src_b} : {{32{bus.src_b[31]}}, bus.src_b};
      prod  = ma * mb;
   end

   // Quotient bits shift into dvd_q as dividend bits shift out; no borrow means rem >= divisor.
   always_comb begin
      rem_sh  = {rem_q, dvd_q[31]};
      diff    = rem_sh - {1'b0, dvs_q};
      ge      = ~diff[32];
      rem_d   = ge ? diff[31:0] : rem_sh[31:0];
      quo_d   = {dvd_q[30:0], ge};
      quo_fix = (sdiv_q && (sa_q ^ sb_q)) ? -quo_d : quo_d;
      rem_fix = (sdiv_q && sa_q) ? -rem_d : rem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         sdiv_q  <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         for (int unsigned i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
      end else begin
         for (int unsigned i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
         if (bus.flush) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.op_valid) begin
                     sdiv_q    <= sdiv;
                     sa_q      <= bus.src_a[31];
                     sb_q      <= bus.src_b[31];
                     dvd_q     <= a_abs;
                     dvs_q     <= b_abs;
                     rem_q     <= '0;
                     pipe_q[0] <= prod;
                     if (!bus.op[1]) begin
                        state_q <= MUL;
                        cnt_q   <= 5'(MUL_LAT - 1);
                     end else if (bus.src_b == '0) begin
                        state_q <= DONE;
                        lo_q    <= '1;
                        hi_q    <= bus.src_a;
                     end else begin
                        state_q <= DIV;
                        cnt_q   <= 5'd31;
                     end
                  end
               end
               MUL: begin
                  cnt_q <= cnt_q - 5'd1;
                  if (cnt_q == '0) begin
                     {hi_q, lo_q} <= pipe_q[MUL_LAT-1];
                     state_q      <= DONE;
                  end
               end
               DIV: begin
                  dvd_q <= quo_d;
                  rem_q <= rem_d;
                  cnt_q <= cnt_q - 5'd1;
                  if (cnt_q == '0) begin
                     lo_q    <= quo_fix;
                     hi_q    <= rem_fix;
                     state_q <= DONE;
                  end
               end
               DONE: begin
                  if (!bus.ex_stall) state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.busy      = bus.op_valid & (state_q != DONE) & ~rst & ~bus.flush;
   assign bus.res_valid = (state_q == DONE);
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed self-checking bench for muldiv_sched at MUL_LAT=2.
module tb_muldiv_sched;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   muldiv_sched_if bus ();

   muldiv_sched #(.MUL_LAT(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] eh, input logic [31:0] el,
                         input string tag);
      bus.op       = o;
      bus.src_a    = a;
      bus.src_b    = b;
      bus.ex_stall = 1'b0;
      bus.op_valid = 1'b1;
      for (int c = 0; c < lat; c++) begin
         #1;
         chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
         chk({tag, ".rv_early"}, 32'(bus.res_valid), 32'd0);
         next_cycle();
      end
      #1;
      chk({tag, ".rv"}, 32'(bus.res_valid), 32'd1);
      chk({tag, ".busy_done"}, 32'(bus.busy), 32'd0);
      chk({tag, ".hi"}, bus.hi, eh);
      chk({tag, ".lo"}, bus.lo, el);
      next_cycle();
      bus.op_valid = 1'b0;
      #1;
      chk({tag, ".rv_after"}, 32'(bus.res_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b1;
      bus.flush    = 1'b0;
      bus.ex_stall = 1'b0;
      bus.op_valid = 1'b1;
      bus.op       = 2'b00;
      bus.src_a    = 32'd5;
      bus.src_b    = 32'd5;
      next_cycle();
      next_cycle();
      #1;
      chk("reset.busy", 32'(bus.busy), 32'd0);
      chk("reset.rv", 32'(bus.res_valid), 32'd0);
      chk("reset.hi", bus.hi, 32'd0);
      chk("reset.lo", bus.lo, 32'd0);
      rst          = 1'b0;
      bus.op_valid = 1'b0;
      next_cycle();

      run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 3, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mul_neg");
      run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 3, 32'd1, 32'hFFFF_FFFE, "mulu");
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFE, 32'd1, "mulu_max");
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'd0, 32'd1, "mul_m1m1");
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg_a");
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, "div_neg_b");
      run_op(2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14, "divu");
      run_op(2'b11, 32'd9, 32'd0, 1, 32'd9, 32'hFFFF_FFFF, "divu_by0");
      run_op(2'b10, 32'hFFFF_FFF8, 32'd0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFF, "div_by0");

      // flush mid-divide at cycle 10
      bus.op       = 2'b10;
      bus.src_a    = 32'd100;
      bus.src_b    = 32'd7;
      bus.op_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("flush.busy_pre", 32'(bus.busy), 32'd1);
         next_cycle();
      end
      bus.flush = 1'b1;
      #1;
      chk("flush.busy_k", 32'(bus.busy), 32'd0);
      next_cycle();
      bus.flush    = 1'b0;
      bus.op_valid = 1'b0;
      #1;
      chk("flush.rv_k1", 32'(bus.res_valid), 32'd0);
      chk("flush.hi_kept", bus.hi, 32'hFFFF_FFF8);
      chk("flush.lo_kept", bus.lo, 32'hFFFF_FFFF);
      next_cycle();
      run_op(2'b01, 32'd3, 32'd4, 3, 32'd0, 32'd12, "mulu_after_flush");

      // result held under ex_stall for 3 cycles
      bus.op       = 2'b00;
      bus.src_a    = 32'd6;
      bus.src_b    = 32'd7;
      bus.ex_stall = 1'b1;
      bus.op_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall.busy", 32'(bus.busy), 32'd1);
         next_cycle();
      end
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall.rv_held", 32'(bus.res_valid), 32'd1);
         chk("stall.busy_held", 32'(bus.busy), 32'd0);
         chk("stall.lo_held", bus.lo, 32'd42);
         next_cycle();
      end
      bus.ex_stall = 1'b0;
      #1;
      chk("stall.rv_consume", 32'(bus.res_valid), 32'd1);
      chk("stall.lo_consume", bus.lo, 32'd42);
      next_cycle();
      bus.op_valid = 1'b0;
      #1;
      chk("stall.rv_after", 32'(bus.res_valid), 32'd0);
      chk("stall.lo_after", bus.lo, 32'd42);
      next_cycle();

      // flush coinciding with consumption drops the result
      bus.op       = 2'b11;
      bus.src_a    = 32'd9;
      bus.src_b    = 32'd0;
      bus.ex_stall = 1'b1;
      bus.op_valid = 1'b1;
      #1;
      chk("fdone.busy0", 32'(bus.busy), 32'd1);
      next_cycle();
      #1;
      chk("fdone.rv", 32'(bus.res_valid), 32'd1);
      bus.flush    = 1'b1;
      bus.ex_stall = 1'b0;
      next_cycle();
      bus.flush    = 1'b0;
      bus.op_valid = 1'b0;
      #1;
      chk("fdone.rv_after", 32'(bus.res_valid), 32'd0);
      chk("fdone.hi", bus.hi, 32'd9);
      chk("fdone.lo", bus.lo, 32'hFFFF_FFFF);
      next_cycle();

      // reset mid-divide
      bus.op       = 2'b10;
      bus.src_a    = 32'hFFFF_FFF9;
      bus.src_b    = 32'd2;
      bus.op_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("rstdiv.busy", 32'(bus.busy), 32'd1);
         next_cycle();
      end
      rst = 1'b1;
      #1;
      chk("rstdiv.busy_rst", 32'(bus.busy), 32'd0);
      next_cycle();
      #1;
      chk("rstdiv.rv", 32'(bus.res_valid), 32'd0);
      chk("rstdiv.hi", bus.hi, 32'd0);
      chk("rstdiv.lo", bus.lo, 32'd0);
      rst          = 1'b0;
      bus.op_valid = 1'b0;
      next_cycle();

      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 3, 32'h4000_0000, 32'd0, "mul_minint");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Sequencing controller for the EX-stage multiply/divide resource. It accepts one MUL/MULU/DIV/DIVU operation at a time from EX, runs a pipelined multiplier or a 32-step restoring divider, and raises a stall request until the 64-bit {hi, lo} result is ready. It holds the result until the pipeline advances past EX, and abandons in-flight work on an exception flush.

## Interface
Parameters:
- MUL_LAT, 2: multiplier pipeline depth in cycles, legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  exception flush; abandons the current operation
- ex_stall  in  1  EX cannot advance this cycle (downstream stall); the result is held
- op_valid  in  1  EX holds a mul/div instruction; must stay stable with op/src_a/src_b until consumed
- op  in  2  00 MUL signed, 01 MULU, 10 DIV signed, 11 DIVU
- src_a  in  32  multiplicand / dividend (rs)
- src_b  in  32  multiplier / divisor (rt)
- busy  out  1  stall request to the stall controller; combinational
- res_valid  out  1  hi/lo hold the finished result
- hi  out  32  product[63:32] or remainder
- lo  out  32  product[31:0] or quotient

## Operation
- States: IDLE, MUL, DIV, DONE. Reset puts the block in IDLE.
- busy = op_valid & (state != DONE) & ~rst & ~flush.
- IDLE:
  - If op_valid & ~flush, latch the operands and op.
  - op[1]=0 goes to MUL with cnt = MUL_LAT-1.
  - op[1]=1 with src_b≠0 goes to DIV with cnt = 31.
  - op[1]=1 with src_b=0 goes straight to DONE with lo=32'hFFFF_FFFF, hi=src_a.
- MUL:
  - Product is {hi, lo} = a*b: signed 64-bit for MUL, zero-extended operands for MULU.
  - It is delayed through a MUL_LAT-stage register pipe.
  - cnt decrements each cycle; at cnt=0, load hi/lo and go to DONE.
- DIV:
  - Unsigned restoring division on |a| and |b|; DIVU uses the raw operands.
  - One quotient bit per cycle, MSB first.
  - 33-bit partial remainder: rem = {rem[31:0], dvd[31]}; if rem ≥ {1'b0, divisor}, subtract and shift in 1, else shift in 0.
  - At cnt=0, apply signed fix-up for DIV:
    - quotient is negated if sign(a) ≠ sign(b);
    - remainder takes the sign of a.
  - Load lo=quotient, hi=remainder, then go to DONE.
- DONE:
  - res_valid=1; hi/lo stable.
  - If ~ex_stall, the result is consumed and the next state is IDLE.
  - An op_valid seen in the consuming cycle belongs to the same instruction and is not restarted.
- flush in any state: next state IDLE, res_valid cleared next cycle, operands discarded, hi/lo unchanged.
- rst dominates flush and every other input. It clears state, cnt, the pipe and hi/lo to 0.

## Timing
- Cycle 0 is the first cycle op_valid is seen in IDLE. busy is high in cycle 0.
- MUL/MULU:
  - busy is high in cycles 0..MUL_LAT.
  - res_valid=1 and busy=0 from cycle MUL_LAT+1; cycle 3 at the default MUL_LAT.
- DIV/DIVU:
  - busy is high in cycles 0..32.
  - res_valid=1 from cycle 33. Latency is data-independent.
- Divide by zero: busy in cycle 0 only; res_valid from cycle 1.
- res_valid stays high while ex_stall=1 and falls the cycle after the first ex_stall=0 in DONE.
- A back-to-back op can be accepted the cycle after DONE exits; there is no bubble beyond this.
- Flush asserted in cycle k: busy=0 in cycle k, state IDLE in cycle k+1, res_valid never rises for that op.
- Reset values: busy 0, res_valid 0, hi 0, lo 0.
- Simultaneous flush and DONE consumption: treat as flush; the result is dropped.

## Test plan
- MUL src_a=32'hFFFF_FFFD (-3), src_b=5 -> busy cycles 0-2; cycle 3 res_valid=1, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1.
- MULU src_a=32'hFFFF_FFFF, src_b=2 -> cycle 3 hi=1, lo=32'hFFFF_FFFE.
- DIV src_a=-7 (32'hFFFF_FFF9), src_b=2 -> busy cycles 0-32; cycle 33 lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- DIVU src_a=100, src_b=7 -> cycle 33 lo=14, hi=2. Then DIVU with src_b=0, src_a=9 -> cycle 1 lo=32'hFFFF_FFFF, hi=9.
- DIV started, flush at cycle 10 -> busy=0 in cycle 10, IDLE at 11, res_valid stays 0. A new MULU 3*4 from cycle 12 -> lo=12 at cycle 15.
- MUL 6*7 with ex_stall held 3 cycles after completion -> res_valid high those 3 cycles plus the consuming cycle, lo=42 stable, then 0. rst asserted mid-DIV -> all outputs 0 next cycle.
